// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory, decode handshake and control signals of the fetch unit
interface fetch_unit_if;
  logic [7:0]  inst_addr;
  logic [15:0] inst_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        halt_req;
  logic        halted;
  logic [15:0] fetch_count;
  modport master (
    output inst_addr, ir, ir_pc, ir_valid, halted, fetch_count,
    input  inst_data, ir_ready, redirect_valid, redirect_addr, halt_req
  );
  modport slave (
    input  inst_addr, ir, ir_pc, ir_valid, halted, fetch_count,
    output inst_data, ir_ready, redirect_valid, redirect_addr, halt_req
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: three-cycle fetch FSM feeding one registered instruction to decode
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD, HALT} state_t;
  state_t      state_q;
  logic [7:0]  pc_q;
  logic [15:0] ir_q;
  logic [7:0]  ir_pc_q;
  logic        ir_valid_q;
  logic        halted_q;
  logic [15:0] fetch_count_q;
  assign bus.inst_addr   = pc_q;
  assign bus.ir          = ir_q;
  assign bus.ir_pc       = ir_pc_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;
  // Sequencing with redirect taking precedence over halt, and halt over normal flow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ISSUE;
      pc_q          <= RESET_PC;
      ir_q          <= 16'h0000;
      ir_pc_q       <= 8'h00;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else if (bus.redirect_valid) begin
      state_q    <= ISSUE;
      pc_q       <= bus.redirect_addr;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else if (bus.halt_req && state_q != HALT) begin
      state_q    <= HALT;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b1;
    end else begin
      case (state_q)
        ISSUE:   state_q <= CAPTURE;
        CAPTURE: begin
          ir_q       <= bus.inst_data;
          ir_pc_q    <= pc_q;
          pc_q       <= pc_q + 8'd1;
          ir_valid_q <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: if (bus.ir_ready) begin
          ir_valid_q    <= 1'b0;
          fetch_count_q <= fetch_count_q + 16'd1;
          state_q       <= ISSUE;
        end
        default: state_q <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic checked against a transaction-level model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] mem [256];
  always @(posedge clk) bus.inst_data <= mem[bus.inst_addr];
  logic [7:0]  m_pc, m_ir_pc;
  logic [15:0] m_ir, m_cnt;
  bit          m_valid, m_halt;
  int          m_t;
  int          ntot = 0;
  int          npass = 0;
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask
  task automatic m_reset();
    m_pc = 8'h00; m_ir = 16'h0000; m_ir_pc = 8'h00;
    m_valid = 0; m_halt = 0; m_cnt = 16'h0000; m_t = 2;
  endtask
  task automatic chk_all();
    chk("inst_addr", bus.inst_addr, m_pc);
    chk("ir", bus.ir, m_ir);
    chk("ir_pc", bus.ir_pc, m_ir_pc);
    chk("ir_valid", bus.ir_valid, m_valid);
    chk("halted", bus.halted, m_halt);
    chk("fetch_count", bus.fetch_count, m_cnt);
  endtask
  task automatic step(input bit rv, input logic [7:0] ra, input bit hr, input bit rdy);
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra;
    bus.halt_req       = hr;
    bus.ir_ready       = rdy;
    if (rv) begin
      m_pc = ra; m_valid = 0; m_halt = 0; m_t = 2;
    end else if (hr && !m_halt) begin
      m_valid = 0; m_halt = 1;
    end else if (!m_halt) begin
      if (m_valid) begin
        if (rdy) begin
          m_valid = 0; m_cnt++; m_t = 2;
        end
      end else begin
        m_t--;
        if (m_t == 0) begin
          m_valid = 1; m_ir = mem[m_pc]; m_ir_pc = m_pc; m_pc++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk_all();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4000;
    mem[1] = 16'h4001;
    bus.redirect_valid = 0; bus.redirect_addr = 0; bus.halt_req = 0; bus.ir_ready = 0;
    m_reset();
    @(negedge clk);
    chk_all();
    rst = 0;
    // first two fetches with decode always ready
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("r32_ir0", bus.ir, 16'h4000);
    chk("r32_valid0", bus.ir_valid, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("r32_ir1", bus.ir, 16'h4001);
    chk("r32_pc1", bus.ir_pc, 8'h01);
    step(0, 0, 0, 1);
    chk("r32_count", bus.fetch_count, 16'd2);
    // decode stalls ten cycles in HOLD
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("r33_pc", bus.ir_pc, 8'h02);
    chk("r33_addr", bus.inst_addr, 8'h03);
    chk("r33_count", bus.fetch_count, 16'd2);
    step(0, 0, 0, 1);
    chk("r33_accept", bus.fetch_count, 16'd3);
    // redirect beats a concurrent acceptance
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 8'h40, 0, 1);
    chk("r35_valid", bus.ir_valid, 1'b0);
    chk("r35_count", bus.fetch_count, 16'd3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("r35_pc", bus.ir_pc, 8'h40);
    // pc wraps from FF to 00
    step(1, 8'hFF, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("r34_pc", bus.ir_pc, 8'hFF);
    step(0, 0, 0, 1);
    chk("r34_addr", bus.inst_addr, 8'h00);
    // halt while capturing, then resume by redirect
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("r36_halted", bus.halted, 1'b1);
    chk("r36_valid", bus.ir_valid, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, i == 1, 1);
    step(1, 8'h10, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("r36_pc", bus.ir_pc, 8'h10);
    // asynchronous reset in the middle of HOLD
    #2 rst = 1;
    m_reset();
    #1 chk_all();
    chk("r37_ir", bus.ir, 16'h0000);
    @(negedge clk);
    rst = 0;
    chk_all();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("r37_restart", bus.ir, 16'h4000);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit rv;
      rv = m_halt ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
      step(rv, 8'($urandom), $urandom_range(29) == 0, 1'($urandom));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 inst_addr  output  8  SHALL be the address driven to instruction memory.
REQ-005 inst_data  input  16  SHALL be instruction memory read data, valid one clk edge after inst_addr is presented.
REQ-006 ir  output  16  SHALL be the registered instruction offered to decode.
REQ-007 ir_pc  output  8  SHALL be the address from which ir was fetched.
REQ-008 ir_valid  output  1  SHALL indicate ir/ir_pc hold an instruction not yet accepted.
REQ-009 ir_ready  input  1  SHALL indicate decode accepts ir this cycle.
REQ-010 redirect_valid  input  1  SHALL request a PC change, e.g. for a branch or jump.
REQ-011 redirect_addr  input  8  SHALL be the new PC when redirect_valid is high.
REQ-012 halt_req  input  1  SHALL request fetching to stop.
REQ-013 halted  output  1  SHALL be high while in HALT.
REQ-014 fetch_count  output  16  SHALL count instructions accepted by decode.

Function
REQ-015 FSM states SHALL be ISSUE, CAPTURE, HOLD, and HALT.
REQ-016 inst_addr SHALL equal the pc register combinationally in every state.
REQ-017 ISSUE: pc is presented; next state SHALL be CAPTURE.
REQ-018 CAPTURE: ir<=inst_data, ir_pc<=pc, pc<=pc+1, ir_valid<=1; next state SHALL be HOLD.
REQ-019 HOLD: ir_valid=1; if ir_ready, ir_valid<=0, fetch_count<=fetch_count+1, and next state SHALL be ISSUE; otherwise stay and keep ir/ir_pc stable.
REQ-020 Fetch latency SHALL be 2 cycles from entering ISSUE to ir_valid high; max throughput SHALL be one instruction per 3 cycles.
REQ-021 pc increment SHALL wrap 8'hFF->8'h00 without flag.
REQ-022 fetch_count SHALL wrap 16'hFFFF->16'h0000.
REQ-023 Priority SHALL be rst > redirect_valid > halt_req > normal sequencing.
REQ-024 redirect_valid in any state: pc<=redirect_addr, ir_valid<=0, next state=ISSUE.
REQ-025 redirect_valid with ir_ready in HOLD: handshake SHALL NOT complete; fetch_count unchanged; held instruction discarded.
REQ-026 redirect_valid in CAPTURE: the inst_data being returned SHALL be discarded.
REQ-027 halt_req (no redirect) in any non-HALT state: ir_valid<=0, next state=HALT, pc unchanged; halt_req with ir_ready in HOLD SHALL NOT count as acceptance.
REQ-028 HALT: halted=1, ir_valid=0, pc held; exit only via redirect_valid (to ISSUE) or rst; halt_req level is ignored there.
REQ-029 ir/ir_pc SHALL change only in CAPTURE.

Reset
REQ-030 On rst assertion, pc<=RESET_PC, state<=ISSUE, ir<=16'h0000, ir_pc<=8'h00, ir_valid<=0, halted<=0, fetch_count<=0, immediately and regardless of clk.
REQ-031 rst asserted mid-operation (any state) SHALL discard any in-flight fetch; first ISSUE after deassertion uses RESET_PC.

Verification
REQ-032 Reset, mem[0]=16'h4000, mem[1]=16'h4001, ir_ready=1 -> ir=16'h4000/ir_pc=0 valid in cycle 2, ir=16'h4001/ir_pc=1 in cycle 5, fetch_count=2.
REQ-033 ir_ready=0 for 10 cycles in HOLD -> ir, ir_pc, ir_valid stable; inst_addr=pc+1; fetch_count unchanged; then ir_ready=1 -> one acceptance.
REQ-034 pc=8'hFF fetched and accepted -> next inst_addr=8'h00, ir_pc=8'hFF.
REQ-035 redirect_valid=1, redirect_addr=8'h40 concurrent with ir_ready=1 in HOLD -> ir_valid drops, fetch_count unchanged, next ir_pc=8'h40.
REQ-036 halt_req=1 in CAPTURE -> halted=1 next cycle, ir_valid=0; redirect_addr=8'h10 later -> resumes, ir_pc=8'h10.
REQ-037 rst pulsed asynchronously mid-HOLD -> outputs reach reset values before next clk edge; fetch restarts at RESET_PC.
